// File: rtl/brisc_pkg.sv
// Shared constants and types for the brisc core; this slice carries what the
// instruction cache controller needs.
package brisc_pkg;

    localparam int ADDRESS_BITS   = 32;
    localparam int BYTE_LEN       = 8;
    localparam int REG_LEN        = 32;
    localparam int CACHE_LINE_LEN = 128;

    localparam int ICACHE_NUM_LINES   = 4;
    localparam int WORD_SEL_BITS      = $clog2(CACHE_LINE_LEN / REG_LEN);
    localparam int ICACHE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);
    localparam int ICACHE_TAG_BITS    = ADDRESS_BITS - ICACHE_OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } icache_state_e;

    // Clears the byte-offset field so the address names a whole line.
    function automatic logic [ADDRESS_BITS-1:0] icache_line_base(
        input logic [ADDRESS_BITS-1:0] addr
    );
        logic [ADDRESS_BITS-1:0] mask;
        mask = {ADDRESS_BITS{1'b1}} << ICACHE_OFFSET_BITS;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the instruction cache: one write port, a flush that clears
// every valid bit, and all lines exposed flat for the parallel tag compare.
module icache_line_array
    import brisc_pkg::*;
#(
    parameter int NUM_LINES = ICACHE_NUM_LINES,
    parameter int TAG_BITS  = ICACHE_TAG_BITS,
    parameter int LINE_BITS = CACHE_LINE_LEN,
    parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [IDX_BITS-1:0]           w_idx,
    input  logic [TAG_BITS-1:0]           w_tag,
    input  logic [LINE_BITS-1:0]          w_data,
    input  logic                          clear_all,
    output logic [NUM_LINES-1:0]          valid,
    output logic [NUM_LINES*TAG_BITS-1:0] tags,
    output logic [NUM_LINES*LINE_BITS-1:0] data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // A write wins over a clear landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (clear_all) begin
                valid_q <= '0;
            end
            if (we) begin
                valid_q[w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data need no reset; they are meaningless while valid is low.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[w_idx]  <= w_tag;
            data_q[w_idx] <= w_data;
        end
    end

    assign valid = valid_q;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_flat
        assign tags[g*TAG_BITS +: TAG_BITS]    = tag_q[g];
        assign data[g*LINE_BITS +: LINE_BITS]  = data_q[g];
    end

endmodule

// File: rtl/icache_ctrl.sv
// Read-only fully-associative instruction cache controller: zero-latency hit
// lookup, and on a miss a request/response refill followed by a replay.
module icache_ctrl
    import brisc_pkg::*;
#(
    parameter int NUM_LINES   = ICACHE_NUM_LINES,
    parameter int LINE_BITS   = CACHE_LINE_LEN,
    parameter int OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN),
    parameter int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [ADDRESS_BITS-1:0] req_addr,
    input  logic                    flush,
    output logic                    resp_valid,
    output logic [REG_LEN-1:0]      resp_data,
    output logic                    stall,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDRESS_BITS-1:0] mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BITS-1:0]    mem_resp_data
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int WSEL_LO  = $clog2(REG_LEN / BYTE_LEN);
    localparam int WSEL_W   = $clog2(LINE_BITS / REG_LEN);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_WAIT = WAIT;

    logic [1:0]              state_q;
    logic [IDX_BITS-1:0]     rp_q;
    logic                    flush_pending_q;
    logic [ADDRESS_BITS-1:0] req_line_q;

    logic [NUM_LINES-1:0]           line_valid;
    logic [NUM_LINES*TAG_BITS-1:0]  line_tags;
    logic [NUM_LINES*LINE_BITS-1:0] line_data;

    logic [TAG_BITS-1:0]  req_tag;
    logic                 hit_any;
    logic [IDX_BITS-1:0]  hit_idx;
    logic                 hit;
    logic [LINE_BITS-1:0] hit_line;
    logic [WSEL_W-1:0]    word_sel;

    logic                 any_invalid;
    logic [IDX_BITS-1:0]  invalid_idx;
    logic [IDX_BITS-1:0]  victim_idx;

    logic                 fill_we;
    logic                 clear_all;

    assign req_tag = req_addr[ADDRESS_BITS-1:OFFSET_BITS];

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (line_valid[i] && (line_tags[i*TAG_BITS +: TAG_BITS] == req_tag)) begin
                hit_any = 1'b1;
                hit_idx = IDX_BITS'(i);
            end
        end
    end

    assign hit      = req_valid && hit_any;
    assign hit_line = line_data[hit_idx*LINE_BITS +: LINE_BITS];
    assign word_sel = req_addr[OFFSET_BITS-1:WSEL_LO];

    always_comb begin
        any_invalid = 1'b0;
        invalid_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!line_valid[i]) begin
                any_invalid = 1'b1;
                invalid_idx = IDX_BITS'(i);
            end
        end
    end

    assign victim_idx = any_invalid ? invalid_idx : rp_q;

    assign fill_we   = !reset && (state_q == ST_WAIT) && mem_resp_valid;
    // A flush raised during a refill waits until the replay cycle has been served.
    assign clear_all = !reset && (state_q == ST_IDLE) && (flush || flush_pending_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rp_q            <= '0;
            flush_pending_q <= 1'b0;
            req_line_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush || flush_pending_q) begin
                        rp_q            <= '0;
                        flush_pending_q <= 1'b0;
                    end
                    if (req_valid && !hit) begin
                        req_line_q <= {req_tag, {OFFSET_BITS{1'b0}}};
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        state_q <= ST_IDLE;
                        if (!any_invalid) begin
                            rp_q <= rp_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_BITS  (TAG_BITS),
        .LINE_BITS (LINE_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .we        (fill_we),
        .w_idx     (victim_idx),
        .w_tag     (req_line_q[ADDRESS_BITS-1:OFFSET_BITS]),
        .w_data    (mem_resp_data),
        .clear_all (clear_all),
        .valid     (line_valid),
        .tags      (line_tags),
        .data      (line_data)
    );

    assign resp_valid    = !reset && (state_q == ST_IDLE) && hit;
    assign resp_data     = hit_line[word_sel*REG_LEN +: REG_LEN];
    assign stall         = !reset && ((state_q == ST_IDLE) ? (req_valid && !hit) : 1'b1);
    assign mem_req_valid = !reset && (state_q == ST_REQ);
    assign mem_req_addr  = req_line_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus a random fetch
// stream checked against a line-level cache model and a refill scoreboard.
module tb_icache_ctrl;
    import brisc_pkg::*;

    localparam int NL = ICACHE_NUM_LINES;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      req_valid;
    logic [ADDRESS_BITS-1:0]   req_addr;
    logic                      flush;
    logic                      resp_valid;
    logic [REG_LEN-1:0]        resp_data;
    logic                      stall;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDRESS_BITS-1:0]   mem_req_addr;
    logic                      mem_resp_valid;
    logic [CACHE_LINE_LEN-1:0] mem_resp_data;

    int total = 0;
    int bad   = 0;

    logic [ADDRESS_BITS-1:0] exp_q[$];

    logic                    m_valid [NL];
    logic [ADDRESS_BITS-1:0] m_line  [NL];
    int                      m_ptr;
    bit                      m_pend;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    // Every accepted refill request must match the next predicted miss.
    always @(posedge clk) begin
        if (!reset && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mem_req_unexpected: got addr=%h, required no request", mem_req_addr);
            end else begin
                logic [ADDRESS_BITS-1:0] e;
                e = exp_q.pop_front();
                if (mem_req_addr !== e) begin
                    bad++;
                    $display("FAIL mem_req_addr: got %h, required %h", mem_req_addr, e);
                end
            end
        end
    end

    function automatic logic [ADDRESS_BITS-1:0] base_of(input logic [ADDRESS_BITS-1:0] a);
        return a & ~32'h0000_000F;
    endfunction

    function automatic logic [31:0] mem_word(input logic [ADDRESS_BITS-1:0] line, input int w);
        logic [31:0] x;
        x = (line ^ 32'h5A5A_0000) * 32'd2654435761;
        return x + (32'(w) * 32'h1111_0101);
    endfunction

    function automatic logic [CACHE_LINE_LEN-1:0] mem_line(input logic [ADDRESS_BITS-1:0] line);
        logic [CACHE_LINE_LEN-1:0] d;
        for (int w = 0; w < 4; w++) d[w*32 +: 32] = mem_word(line, w);
        return d;
    endfunction

    function automatic int m_find(input logic [ADDRESS_BITS-1:0] a);
        for (int i = 0; i < NL; i++)
            if (m_valid[i] && m_line[i] == base_of(a)) return i;
        return -1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void m_fill(input logic [ADDRESS_BITS-1:0] a);
        int v;
        v = -1;
        for (int i = 0; i < NL; i++)
            if (!m_valid[i] && v < 0) v = i;
        if (v < 0) begin
            v = m_ptr;
            m_ptr = (m_ptr + 1) % NL;
        end
        m_valid[v] = 1'b1;
        m_line[v]  = base_of(a);
    endfunction

    task automatic apply_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_clear();
        m_pend = 1'b0;
        exp_q.delete();
    endtask

    // One fetch from IDLE through to service; returns at posedge+1 after the
    // serving cycle so the next fetch can follow back to back.
    task automatic fetch(input logic [ADDRESS_BITS-1:0] a, input bit flush_now,
                         input bit flush_wait, input int rdy_delay, input int lat);
        bit exp_hit;
        logic [31:0] exp_w;
        exp_hit = (m_find(a) >= 0);
        exp_w = mem_word(base_of(a), int'(a[3:2]));
        req_valid = 1'b1; req_addr = a; flush = flush_now;
        @(negedge clk);
        total++;
        if (exp_hit) begin
            if (resp_valid !== 1'b1 || stall !== 1'b0 || resp_data !== exp_w || mem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL hit %h: got rv=%b st=%b data=%h mrv=%b, required rv=1 st=0 data=%h mrv=0",
                         a, resp_valid, stall, resp_data, mem_req_valid, exp_w);
            end
        end else if (resp_valid !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL miss_detect %h: got rv=%b st=%b, required rv=0 st=1", a, resp_valid, stall);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        if (flush_now) m_clear();
        if (exp_hit) return;
        exp_q.push_back(base_of(a));
        for (int i = 0; i <= rdy_delay; i++) begin
            mem_req_ready = (i == rdy_delay);
            @(negedge clk);
            total++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== base_of(a) || stall !== 1'b1 || resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL req_phase %h: got mrv=%b addr=%h st=%b rv=%b, required mrv=1 addr=%h st=1 rv=0",
                         a, mem_req_valid, mem_req_addr, stall, resp_valid, base_of(a));
            end
            @(posedge clk);
            #1 mem_req_ready = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin
            flush = flush_wait && (i == 0);
            @(negedge clk);
            total++;
            if (mem_req_valid !== 1'b0 || stall !== 1'b1 || resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_phase %h: got mrv=%b st=%b rv=%b, required mrv=0 st=1 rv=0",
                         a, mem_req_valid, stall, resp_valid);
            end
            @(posedge clk);
            #1;
            if (flush) m_pend = 1'b1;
            flush = 1'b0;
        end
        mem_resp_valid = 1'b1; mem_resp_data = mem_line(base_of(a));
        @(negedge clk);
        total++;
        if (mem_req_valid !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL fill_cycle %h: got mrv=%b st=%b, required mrv=0 st=1", a, mem_req_valid, stall);
        end
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        m_fill(a);
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || stall !== 1'b0 || resp_data !== exp_w || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL replay %h: got rv=%b st=%b data=%h mrv=%b, required rv=1 st=0 data=%h mrv=0",
                     a, resp_valid, stall, resp_data, mem_req_valid, exp_w);
        end
        @(posedge clk);
        #1;
        if (m_pend) begin
            m_clear();
            m_pend = 1'b0;
        end
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_addr = 32'h40; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || stall !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rv=%b st=%b mrv=%b addr=%h, required all zero",
                     resp_valid, stall, mem_req_valid, mem_req_addr);
        end
        apply_reset();
    endtask

    task automatic test_cold_miss_and_hits();
        fetch(32'h40, 0, 0, 3, 5);
        fetch(32'h44, 0, 0, 0, 1);
        fetch(32'h48, 0, 0, 0, 1);
        fetch(32'h4C, 0, 0, 0, 1);
        go_idle();
    endtask

    task automatic test_replacement();
        apply_reset();
        fetch(32'h000, 0, 0, 0, 2);
        fetch(32'h040, 0, 0, 1, 1);
        fetch(32'h080, 0, 0, 0, 3);
        fetch(32'h0C0, 0, 0, 2, 1);
        fetch(32'h100, 0, 0, 0, 2);
        fetch(32'h044, 0, 0, 0, 1);
        fetch(32'h000, 0, 0, 0, 1);
        fetch(32'h08C, 0, 0, 0, 1);
        fetch(32'h104, 0, 0, 0, 1);
        go_idle();
    endtask

    task automatic test_flush_wait();
        fetch(32'h200, 0, 1, 1, 3);
        fetch(32'h104, 0, 0, 0, 1);
        fetch(32'h208, 0, 0, 0, 2);
        go_idle();
    endtask

    task automatic test_flush_idle();
        fetch(32'h20C, 1, 0, 0, 1);
        fetch(32'h200, 0, 0, 0, 1);
        fetch(32'h500, 1, 0, 1, 2);
        fetch(32'h204, 0, 0, 0, 1);
        go_idle();
    endtask

    task automatic test_reset_mid_refill();
        req_valid = 1'b1; req_addr = 32'h300;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL rst_refill_detect: got st=%b, required st=1", stall);
        end
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        exp_q.push_back(32'h300);
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        m_clear(); m_pend = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = mem_line(32'h300);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_refill_abort: got st=%b rv=%b mrv=%b, required all zero",
                     stall, resp_valid, mem_req_valid);
        end
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        fetch(32'h304, 0, 0, 0, 2);
        go_idle();
    endtask

    task automatic test_back_to_back();
        fetch(32'h400, 0, 0, 0, 1);
        fetch(32'h440, 0, 0, 0, 1);
        fetch(32'h448, 0, 0, 0, 1);
        fetch(32'h404, 0, 0, 0, 1);
        go_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [ADDRESS_BITS-1:0] a;
            a = (32'($urandom_range(0, 6)) << 6) | (32'($urandom_range(0, 3)) << 2);
            fetch(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 3), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hits();
        test_replacement();
        test_flush_wait();
        test_flush_idle();
        test_reset_mid_refill();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL refill_count: got %0d requests outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
